// File: rtl/n64_controller_phy_if.sv
// Control levels, pad signals and status between the APB register block,
// the N64 controller PHY and the open-drain pad.
interface n64_controller_phy_if;
  localparam int unsigned BUTTON_W = 32;

  logic                polling_enable;
  logic                controller_reset;
  logic                data_in;
  logic                data_oe;
  logic [BUTTON_W-1:0] button_data;
  logic                data_valid;
  logic                rx_timeout;
  logic                busy;

  modport master (
    output polling_enable, controller_reset, data_in,
    input  data_oe, button_data, data_valid, rx_timeout, busy
  );

  modport slave (
    input  polling_enable, controller_reset, data_in,
    output data_oe, button_data, data_valid, rx_timeout, busy
  );
endinterface

// File: rtl/n64_controller_phy.sv
// One-wire N64 controller engine: sends 0xFF/0x01 commands and deserialises replies.
// Optional N64_GLITCH_FILTER_EN adds a 3-sample majority filter on the synced line.
module n64_controller_phy #(
  parameter int unsigned US_CYCLES   = 100,
  parameter int unsigned POLL_GAP_US = 1000,
  parameter int unsigned TIMEOUT_US  = 100
) (
  input logic                 PCLK,
  input logic                 PRESERN,
  n64_controller_phy_if.slave bus
);

  localparam int unsigned GAP_CYC  = POLL_GAP_US * US_CYCLES;
  localparam int unsigned TO_CYC   = TIMEOUT_US * US_CYCLES;
  localparam int unsigned BIT3_CYC = 3 * US_CYCLES;
  localparam int unsigned LONG_CYC = (GAP_CYC > TO_CYC) ? GAP_CYC : TO_CYC;
  localparam int unsigned CNT_MAX  = (LONG_CYC > BIT3_CYC) ? LONG_CYC : BIT3_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W    = 6;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE, TX, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_HIGH, GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tx_sh_q, tx_sh_d;
  logic [2:0]          tx_idx_q, tx_idx_d;
  logic                tx_hi_q, tx_hi_d;
  logic [BIT_W-1:0]    expected_q, expected_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                poll_q, poll_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   button_q, button_d;
  logic                dv_q, dv_d;
  logic                to_q, to_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                reset_pending_q, reset_pending_d;
  logic                ctrl_reset_q, ctrl_reset_d;
  logic [1:0]          sync_q, sync_d;
  logic                rx_prev_q, rx_prev_d;
  logic                line_s;
  logic                rx_line;

  // Low (driven) and high (released) phase lengths of one command bit, minus one.
  function automatic logic [CNT_W-1:0] low_len(input logic b);
    return b ? CNT_W'(US_CYCLES - 1) : CNT_W'(BIT3_CYC - 1);
  endfunction

  function automatic logic [CNT_W-1:0] high_len(input logic b);
    return b ? CNT_W'(BIT3_CYC - 1) : CNT_W'(US_CYCLES - 1);
  endfunction

  assign line_s = sync_q[1];

`ifdef N64_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       line_f_q, line_f_d;

  // Majority of three consecutive synced samples; a lone one-cycle pulse never wins.
  always_comb begin
    hist_d   = {hist_q[0], line_s};
    line_f_d = (line_s & hist_q[0]) | (line_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      hist_q   <= 2'b11;
      line_f_q <= 1'b1;
    end else begin
      hist_q   <= hist_d;
      line_f_q <= line_f_d;
    end
  end

  assign rx_line = line_f_q;
`else
  assign rx_line = line_s;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tx_sh_d         = tx_sh_q;
    tx_idx_d        = tx_idx_q;
    tx_hi_d         = tx_hi_q;
    expected_d      = expected_q;
    bit_cnt_d       = bit_cnt_q;
    poll_d          = poll_q;
    shift_d         = shift_q;
    button_d        = button_q;
    dv_d            = 1'b0;
    to_d            = 1'b0;
    reset_pending_d = reset_pending_q;
    ctrl_reset_d    = bus.controller_reset;
    sync_d          = {sync_q[0], bus.data_in};
    rx_prev_d       = rx_line;

    unique case (state_q)
      IDLE: begin
        if (reset_pending_q) begin
          reset_pending_d = 1'b0;
          tx_sh_d         = 8'hFF;
          expected_d      = BIT_W'(24);
          poll_d          = 1'b0;
          cnt_d           = low_len(1'b1);
          state_d         = TX;
        end else if (bus.polling_enable) begin
          tx_sh_d         = 8'h01;
          expected_d      = BIT_W'(32);
          poll_d          = 1'b1;
          cnt_d           = low_len(1'b0);
          state_d         = TX;
        end
        tx_idx_d  = 3'd0;
        tx_hi_d   = 1'b0;
        bit_cnt_d = '0;
        shift_d   = '0;
      end

      TX: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!tx_hi_q) begin
          tx_hi_d = 1'b1;
          cnt_d   = high_len(tx_sh_q[7]);
        end else if (tx_idx_q == 3'd7) begin
          cnt_d   = CNT_W'(US_CYCLES - 1);
          state_d = TX_STOP;
        end else begin
          tx_idx_d = tx_idx_q + 3'd1;
          tx_hi_d  = 1'b0;
          tx_sh_d  = {tx_sh_q[6:0], 1'b0};
          cnt_d    = low_len(tx_sh_q[6]);
        end
      end

      TX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(TO_CYC - 1);
          state_d = RX_WAIT_FALL;
        end
      end

      RX_WAIT_FALL: begin
        if (rx_prev_q && !rx_line) begin
          cnt_d   = CNT_W'(2 * US_CYCLES - 1);
          state_d = RX_SAMPLE;
        end else if (cnt_q == '0) begin
          to_d    = 1'b1;
          cnt_d   = CNT_W'(GAP_CYC - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Mid-bit sample: 2 us after the falling edge separates 1 us and 3 us lows.
      RX_SAMPLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d   = {shift_q[DATA_W-2:0], rx_line};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          cnt_d     = CNT_W'(TO_CYC - 1);
          state_d   = RX_WAIT_HIGH;
        end
      end

      RX_WAIT_HIGH: begin
        if (rx_line) begin
          if (bit_cnt_q == expected_q) begin
            if (poll_q) begin
              button_d = shift_q;
              dv_d     = 1'b1;
            end
            cnt_d   = CNT_W'(GAP_CYC - 1);
            state_d = GAP;
          end else begin
            cnt_d   = CNT_W'(TO_CYC - 1);
            state_d = RX_WAIT_FALL;
          end
        end else if (cnt_q == '0) begin
          to_d    = 1'b1;
          cnt_d   = CNT_W'(GAP_CYC - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new request edge wins over the clear so back-to-back requests are not lost.
    if (bus.controller_reset && !ctrl_reset_q) begin
      reset_pending_d = 1'b1;
    end

    oe_d   = ((state_d == TX) && !tx_hi_d) || (state_d == TX_STOP);
    busy_d = !(state_d inside {IDLE, GAP});
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      tx_sh_q         <= '0;
      tx_idx_q        <= '0;
      tx_hi_q         <= 1'b0;
      expected_q      <= '0;
      bit_cnt_q       <= '0;
      poll_q          <= 1'b0;
      shift_q         <= '0;
      button_q        <= '0;
      dv_q            <= 1'b0;
      to_q            <= 1'b0;
      oe_q            <= 1'b0;
      busy_q          <= 1'b0;
      reset_pending_q <= 1'b0;
      ctrl_reset_q    <= 1'b0;
      sync_q          <= 2'b11;
      rx_prev_q       <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tx_sh_q         <= tx_sh_d;
      tx_idx_q        <= tx_idx_d;
      tx_hi_q         <= tx_hi_d;
      expected_q      <= expected_d;
      bit_cnt_q       <= bit_cnt_d;
      poll_q          <= poll_d;
      shift_q         <= shift_d;
      button_q        <= button_d;
      dv_q            <= dv_d;
      to_q            <= to_d;
      oe_q            <= oe_d;
      busy_q          <= busy_d;
      reset_pending_q <= reset_pending_d;
      ctrl_reset_q    <= ctrl_reset_d;
      sync_q          <= sync_d;
      rx_prev_q       <= rx_prev_d;
    end
  end

  assign bus.data_oe     = oe_q;
  assign bus.button_data = button_q;
  assign bus.data_valid  = dv_q;
  assign bus.rx_timeout  = to_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_n64_controller_phy.sv
// Bench for n64_controller_phy: decodes the command waveform and plays the controller.
module tb_n64_controller_phy;

  localparam int unsigned US       = 4;
  localparam int unsigned GAP_US   = 30;
  localparam int unsigned TO_US    = 20;
  localparam int unsigned G        = GAP_US * US;
  localparam int unsigned T        = TO_US * US;
  localparam int          WAIT_MAX = 4000;

  logic clk;
  logic rst_n;
  logic ctl_low;

  n64_controller_phy_if bus ();

  n64_controller_phy #(
    .US_CYCLES  (US),
    .POLL_GAP_US(GAP_US),
    .TIMEOUT_US (TO_US)
  ) dut (
    .PCLK   (clk),
    .PRESERN(rst_n),
    .bus    (bus)
  );

  // Open-drain line with pull-up: low if either side drives.
  assign bus.data_in = ~(bus.data_oe | ctl_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          dv_count, to_count, oe_starts, oe_bad, dv_long, last_done;
  logic        dv_prev, oe_prev;
  int          cap_len [17];
  int          exp_len [17];
  int          cap_start, cap_end;
  logic        cap_ok;
  logic [7:0]  cap_byte;
  logic [31:0] model_btn;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dv_count = 0; to_count = 0; oe_starts = 0; oe_bad = 0; dv_long = 0; last_done = 0;
    dv_prev = 1'b0; oe_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_count++;
      last_done = cyc;
      if (dv_prev === 1'b1) dv_long++;
    end
    if (bus.rx_timeout === 1'b1) begin
      to_count++;
      last_done = cyc;
    end
    if (bus.data_oe === 1'b1 && oe_prev !== 1'b1) oe_starts++;
    if (bus.data_oe === 1'b1 && bus.busy !== 1'b1) oe_bad++;
    dv_prev = bus.data_valid;
    oe_prev = bus.data_oe;
  end

  // Reference waveform: slot 2i = driven-low length, 2i+1 = released length, 16 = stop.
  function automatic void fill_exp(input logic [7:0] cmd);
    for (int i = 0; i < 8; i++) begin
      exp_len[2*i]   = cmd[7-i] ? US : 3 * US;
      exp_len[2*i+1] = cmd[7-i] ? 3 * US : US;
    end
    exp_len[16] = US;
  endfunction

  function automatic int wave_diff();
    int d = 0;
    for (int i = 0; i < 17; i++) if (cap_len[i] != exp_len[i]) d++;
    return d;
  endfunction

  task automatic capture_cmd();
    int   n;
    logic lvl;
    cap_ok   = 1'b0;
    cap_byte = '0;
    n = 0;
    while (bus.data_oe !== 1'b1 && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (bus.data_oe !== 1'b1) return;
    cap_start = cyc;
    for (int i = 0; i < 17; i++) begin
      lvl = (i % 2 == 0);
      n = 0;
      while (bus.data_oe === lvl && n < WAIT_MAX) begin @(negedge clk); n++; end
      cap_len[i] = n;
    end
    cap_end = cyc;
    for (int b = 0; b < 8; b++) cap_byte[7-b] = (cap_len[2*b] < cap_len[2*b+1]);
    cap_ok = (bus.data_oe === 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits, input int first, input int last);
    logic b;
    for (int i = first; i < last; i++) begin
      b = w[nbits-1-i];
      ctl_low = 1'b1;
      repeat (b ? US : 3 * US) @(negedge clk);
      ctl_low = 1'b0;
      repeat (b ? 3 * US : US) @(negedge clk);
    end
  endtask

  task automatic send_stop();
    ctl_low = 1'b1;
    repeat (US) @(negedge clk);
    ctl_low = 1'b0;
    repeat (2 * US) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.polling_enable   = 1'b0;
    bus.controller_reset = 1'b1;
    ctl_low = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (bus.data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", bus.data_oe); end
    vectors++; if (bus.button_data !== 32'h0) begin miscompares++; $display("FAIL reset_button: got %h want 0", bus.button_data); end
    vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %b want 0", bus.data_valid); end
    vectors++; if (bus.rx_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_to: got %b want 0", bus.rx_timeout); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    model_btn = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_cmd();
    int dv0, st0;
    logic [31:0] w;
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'hFF) begin miscompares++; $display("FAIL reset_cmd_byte: got %h ok=%b want ff", cap_byte, cap_ok); end
    fill_exp(8'hFF);
    vectors++; if (wave_diff() !== 0) begin miscompares++; $display("FAIL reset_cmd_wave: %0d slots differ, want 0", wave_diff()); end
    dv0 = dv_count; st0 = oe_starts;
    repeat (2 * US) @(negedge clk);
    w = $urandom;
    send_bits(w, 24, 0, 24);
    send_stop();
    vectors++; if (dv_count !== dv0) begin miscompares++; $display("FAIL reset_resp_dv: got %0d pulses want 0", dv_count - dv0); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL reset_resp_button: got %h want %h", bus.button_data, model_btn); end
    repeat (G + 40) @(negedge clk);
    vectors++; if (oe_starts !== st0) begin miscompares++; $display("FAIL reset_level_single: got %0d extra cmds want 0", oe_starts - st0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_poll_basic();
    int dv0;
    logic [31:0] w;
    bus.controller_reset = 1'b0;
    bus.polling_enable   = 1'b1;
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'h01) begin miscompares++; $display("FAIL poll_cmd_byte: got %h ok=%b want 01", cap_byte, cap_ok); end
    fill_exp(8'h01);
    vectors++; if (wave_diff() !== 0) begin miscompares++; $display("FAIL poll_cmd_wave: %0d slots differ, want 0", wave_diff()); end
    dv0 = dv_count;
    w = 32'h8000_0001;
    repeat (2 * US) @(negedge clk);
    send_bits(w, 32, 0, 32);
    send_stop();
    model_btn = w;
    vectors++; if (dv_count !== dv0 + 1) begin miscompares++; $display("FAIL poll_dv: got %0d pulses want 1", dv_count - dv0); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL poll_button: got %h want %h", bus.button_data, model_btn); end
  endtask

  task automatic test_timeout();
    int dv0, to0, n;
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'h01) begin miscompares++; $display("FAIL to_cmd_byte: got %h ok=%b want 01", cap_byte, cap_ok); end
    vectors++; if (cap_start - last_done !== G + 1) begin miscompares++; $display("FAIL poll_gap: got %0d want %0d", cap_start - last_done, G + 1); end
    dv0 = dv_count; to0 = to_count; n = 0;
    while (to_count == to0 && n < T + 20) begin @(negedge clk); n++; end
    vectors++; if (to_count !== to0 + 1) begin miscompares++; $display("FAIL to_pulse: got %0d pulses want 1", to_count - to0); end
    vectors++; if (last_done - cap_end !== T) begin miscompares++; $display("FAIL to_latency: got %0d want %0d", last_done - cap_end, T); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL to_button_kept: got %h want %h", bus.button_data, model_btn); end
    vectors++; if (dv_count !== dv0) begin miscompares++; $display("FAIL to_no_dv: got %0d pulses want 0", dv_count - dv0); end
  endtask

  task automatic test_random_polls();
    int dv0;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      capture_cmd();
      fill_exp(8'h01);
      vectors++; if (!cap_ok || wave_diff() !== 0) begin miscompares++; $display("FAIL rand_cmd_wave[%0d]: %0d slots differ ok=%b", k, wave_diff(), cap_ok); end
      vectors++; if (cap_start - last_done !== G + 1) begin miscompares++; $display("FAIL rand_gap[%0d]: got %0d want %0d", k, cap_start - last_done, G + 1); end
      dv0 = dv_count;
      w = $urandom;
      repeat (2 * US) @(negedge clk);
      send_bits(w, 32, 0, 32);
      send_stop();
      model_btn = w;
      vectors++; if (dv_count !== dv0 + 1) begin miscompares++; $display("FAIL rand_dv[%0d]: got %0d pulses want 1", k, dv_count - dv0); end
      vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL rand_button[%0d]: got %h want %h", k, bus.button_data, model_btn); end
    end
  endtask

  task automatic test_reset_mid_poll();
    int dv0;
    logic [31:0] w;
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'h01) begin miscompares++; $display("FAIL mid_cmd_byte: got %h want 01", cap_byte); end
    dv0 = dv_count;
    w = $urandom;
    repeat (2 * US) @(negedge clk);
    send_bits(w, 32, 0, 10);
    bus.controller_reset = 1'b1;
    send_bits(w, 32, 10, 32);
    send_stop();
    model_btn = w;
    vectors++; if (dv_count !== dv0 + 1) begin miscompares++; $display("FAIL mid_dv: got %0d pulses want 1", dv_count - dv0); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL mid_button: got %h want %h", bus.button_data, model_btn); end
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'hFF) begin miscompares++; $display("FAIL mid_next_cmd: got %h want ff", cap_byte); end
    vectors++; if (cap_start - last_done !== G + 1) begin miscompares++; $display("FAIL mid_gap: got %0d want %0d", cap_start - last_done, G + 1); end
    repeat (2 * US) @(negedge clk);
    send_bits($urandom, 24, 0, 24);
    send_stop();
    capture_cmd();
    vectors++; if (!cap_ok || cap_byte !== 8'h01) begin miscompares++; $display("FAIL mid_single_ff: got %h want 01", cap_byte); end
    dv0 = dv_count;
    w = $urandom | 32'h1;
    repeat (2 * US) @(negedge clk);
    send_bits(w, 32, 0, 32);
    send_stop();
    model_btn = w;
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL mid_after_button: got %h want %h", bus.button_data, model_btn); end
  endtask

`ifdef N64_GLITCH_FILTER_EN
  task automatic test_glitch();
    int dv0;
    logic [31:0] w;
    capture_cmd();
    dv0 = dv_count;
    w = 32'hA5C3_0F96;
    repeat (6) @(negedge clk);
    ctl_low = 1'b1;
    @(negedge clk);
    ctl_low = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(w, 32, 0, 32);
    send_stop();
    model_btn = w;
    vectors++; if (dv_count !== dv0 + 1) begin miscompares++; $display("FAIL glitch_dv: got %0d pulses want 1", dv_count - dv0); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL glitch_button: got %h want %h", bus.button_data, model_btn); end
  endtask
`endif

  task automatic test_reset_during_rx();
    int st0;
    capture_cmd();
    repeat (2 * US) @(negedge clk);
    send_bits($urandom, 32, 0, 10);
    ctl_low = 1'b1;
    repeat (US) @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rx_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    bus.polling_enable   = 1'b0;
    bus.controller_reset = 1'b0;
    @(negedge clk);
    model_btn = '0;
    vectors++; if (bus.data_oe !== 1'b0) begin miscompares++; $display("FAIL rx_rst_oe: got %b want 0", bus.data_oe); end
    vectors++; if (bus.button_data !== model_btn) begin miscompares++; $display("FAIL rx_rst_button: got %h want %h", bus.button_data, model_btn); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rx_rst_busy: got %b want 0", bus.busy); end
    ctl_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st0 = oe_starts;
    repeat (3 * G) @(negedge clk);
    vectors++; if (oe_starts !== st0) begin miscompares++; $display("FAIL rx_rst_idle: got %0d cmds want 0", oe_starts - st0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rx_rst_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_invariants();
    vectors++; if (oe_bad !== 0) begin miscompares++; $display("FAIL oe_outside_tx: got %0d cycles want 0", oe_bad); end
    vectors++; if (dv_long !== 0) begin miscompares++; $display("FAIL dv_width: got %0d long pulses want 0", dv_long); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ctl_low = 1'b0;
    bus.polling_enable = 1'b0;
    bus.controller_reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_cmd();
    test_poll_basic();
    test_timeout();
    test_random_polls();
    test_reset_mid_poll();
`ifdef N64_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_during_rx();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
